// File: rtl/knn_pkg.sv
// Shared KNN definitions: default widths, the distance-width rule and the FSM encoding.
// Included by both the distance stage and the sorter so the distance width agrees on both sides.
package knn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int IDX_W_DEF  = 8;

  // Worst case (2**DATA_W)**2 * 2 needs 2*DATA_W+2 bits.
  function automatic int dist_w(input int data_w);
    return 2 * data_w + 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/knn_sq_diff.sv
// One axis of the distance pipeline: subtract, then square (or absolute value when
// KNN_DIST_L1_EN is defined). Two register stages; the valid bit travels alongside.
module knn_sq_diff
  import knn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic                     s1_valid,
  output logic                     out_valid,
  output logic [2*DATA_W+1:0]      res
);

  localparam int RES_W = 2 * DATA_W + 2;

  logic signed [DATA_W:0] diff;
  logic [RES_W-1:0]       res_d;

`ifdef KNN_DIST_L1_EN
  logic [DATA_W:0] mag;
  // |diff| never overflows DATA_W+1 bits: the most negative difference is -(2**DATA_W-1).
  assign mag   = diff[DATA_W] ? DATA_W'(0) - diff : diff;
  assign res_d = RES_W'(mag);
`else
  logic signed [RES_W-1:0] diff_ext;
  assign diff_ext = RES_W'(diff);
  assign res_d    = $unsigned(diff_ext * diff_ext);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff      <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      res       <= '0;
    end else begin
      s1_valid  <= in_valid & ~clr;
      out_valid <= s1_valid & ~clr;
      if (in_valid) diff <= {a[DATA_W-1], a} - {b[DATA_W-1], b};
      if (s1_valid) res <= res_d;
    end
  end

endmodule

// File: rtl/knn_dist_stage.sv
// KNN distance stage: streams training points against a latched test point and emits
// {distance, index} beats for the sorter. Build option: KNN_DIST_L1_EN selects |dx|+|dy|.
module knn_dist_stage
  import knn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DIST_W = dist_w(DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] TEST_X,
  input  logic signed [DATA_W-1:0] TEST_Y,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] DATA_X,
  input  logic signed [DATA_W-1:0] DATA_Y,
  output logic                     out_valid,
  output logic [DIST_W-1:0]        out_dist,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     done,
  output logic                     busy,
  output logic                     overflow
);

  localparam int               SQ_W    = 2 * DATA_W + 2;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] tx, ty;
  logic [IDX_W-1:0]         idx, idx_s1, idx_s2;
  logic                     idx_sat;
  logic                     accept, drop;
  logic                     x_s1v, y_s1v, x_s2v, y_s2v;
  logic                     s1_busy, s2_valid;
  logic [SQ_W-1:0]          sx, sy, sum;

  assign accept   = (state == RUN) && in_valid && !start && !idx_sat;
  assign drop     = (state == RUN) && in_valid && !start && idx_sat;
  assign s1_busy  = x_s1v | y_s1v;
  assign s2_valid = x_s2v & y_s2v;
  assign sum      = sx + sy;
  assign busy     = (state == RUN) || (state == FLUSH);
  assign done     = (state == DONE);

  knn_sq_diff #(.DATA_W(DATA_W)) u_x (
    .clk(clk), .rst(rst), .clr(start), .in_valid(accept),
    .a(DATA_X), .b(tx), .s1_valid(x_s1v), .out_valid(x_s2v), .res(sx)
  );

  knn_sq_diff #(.DATA_W(DATA_W)) u_y (
    .clk(clk), .rst(rst), .clr(start), .in_valid(accept),
    .a(DATA_Y), .b(ty), .s1_valid(y_s1v), .out_valid(y_s2v), .res(sy)
  );

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        IDLE:  state_nxt = IDLE;
        RUN:   if (in_valid && in_last) state_nxt = FLUSH;
        // Once S1/S2 are empty, the final beat (if any) is at S3 this cycle.
        FLUSH: if (!s1_busy && !s2_valid) state_nxt = DONE;
        DONE:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tx        <= '0;
      ty        <= '0;
      idx       <= '0;
      idx_sat   <= 1'b0;
      overflow  <= 1'b0;
      idx_s1    <= '0;
      idx_s2    <= '0;
      out_valid <= 1'b0;
      out_dist  <= '0;
      out_idx   <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        tx       <= TEST_X;
        ty       <= TEST_Y;
        idx      <= '0;
        idx_sat  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (accept) begin
          idx_s1 <= idx;
          if (idx == IDX_MAX) idx_sat <= 1'b1;
          else                idx     <= idx + 1'b1;
        end
        if (drop) overflow <= 1'b1;
      end
      if (s1_busy) idx_s2 <= idx_s1;
      // start flushes the S3 valid too, so an aborted beat never surfaces.
      out_valid <= s2_valid & ~start;
      if (s2_valid) begin
        out_dist <= DIST_W'(sum);
        out_idx  <= idx_s2;
      end
    end
  end

endmodule
